// File: rtl/memunit.sv
// memunit: 512-byte synchronous memory responder for cpuunit (req/busy handshake).
// Serves single-byte reads, three-byte instruction fetch bursts and single-byte writes.
//
// Parameters:
//   MEMORY_FILE  memory image name (kept for interface compatibility)
//   WAIT_STATES  wait cycles before the first data beat, 0..7
// Optional feature:
//   MEMUNIT_ROM_PROTECT_EN  when defined, 0x100-0x1FF is read-only and
//                           a write there pulses err together with done
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req, we, burst      request strobe, write select, 3-beat read burst
//   addr, wdata         byte address (addr[8:0] used), write data
//   busy                request in progress, new req ignored
//   rvalid, rdata       read beat strobe and data (rdata holds otherwise)
//   rlast               final read beat
//   done, err           write completion pulse, write-rejected pulse

package memunit_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;
    typedef logic [8:0]  ptr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_XFER
    } state_t;

    // Request captured at acceptance and walked through the transfer.
    typedef struct packed {
        ptr_t       ptr;
        logic       we;
        data_t      wdata;
        logic [1:0] beats;
    } xfer_t;

endpackage

module memunit
    import memunit_pkg::*;
#(
    parameter string MEMORY_FILE = "test/cpumemory_test.mem",
    parameter int    WAIT_STATES = 0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  req,
    input  logic  we,
    input  logic  burst,
    input  addr_t addr,
    input  data_t wdata,
    output logic  busy,
    output logic  rvalid,
    output data_t rdata,
    output logic  rlast,
    output logic  done,
    output logic  err
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    data_t      mem [0:511];

    state_t     state;
    state_t     nstate;
    xfer_t      cur;
    xfer_t      ncur;
    logic [2:0] wcnt;
    logic [2:0] nwcnt;
    logic       nrvalid;
    logic       nrlast;
    logic       ndone;
    logic       rd_en;
    logic       wr_en;
    logic       rom_hit;

    // Upper address bits are deliberately ignored.
    wire unused_addr = &{1'b0, addr[15:9]};

`ifdef MEMUNIT_ROM_PROTECT_EN
    logic nerr;
    assign rom_hit = cur.ptr[8];
`else
    assign rom_hit = 1'b0;
    assign err     = 1'b0;
`endif

    assign busy = (state != S_IDLE);

    // Next-state and next-transfer logic.
    always_comb begin
        nstate  = state;
        ncur    = cur;
        nwcnt   = wcnt;
        nrvalid = 1'b0;
        nrlast  = 1'b0;
        ndone   = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
`ifdef MEMUNIT_ROM_PROTECT_EN
        nerr    = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (req) begin
                    ncur.ptr   = addr[8:0];
                    ncur.we    = we;
                    ncur.wdata = wdata;
                    ncur.beats = (burst && !we) ? 2'd3 : 2'd1;
                    if (WS != 3'd0) begin
                        nstate = S_WAIT;
                        nwcnt  = WS;
                    end else begin
                        nstate = S_XFER;
                    end
                end
            end
            S_WAIT: begin
                nwcnt = wcnt - 3'd1;
                if (wcnt == 3'd1) begin
                    nstate = S_XFER;
                end
            end
            S_XFER: begin
                if (cur.we) begin
                    wr_en  = !rom_hit;
                    ndone  = 1'b1;
`ifdef MEMUNIT_ROM_PROTECT_EN
                    nerr   = rom_hit;
`endif
                    nstate = S_IDLE;
                end else begin
                    rd_en      = 1'b1;
                    nrvalid    = 1'b1;
                    ncur.ptr   = cur.ptr + 9'd1;
                    ncur.beats = cur.beats - 2'd1;
                    if (cur.beats == 2'd1) begin
                        nrlast = 1'b1;
                        nstate = S_IDLE;
                    end
                end
            end
            default: begin
                nstate = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cur    <= '0;
            wcnt   <= 3'd0;
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= nstate;
            cur    <= ncur;
            wcnt   <= nwcnt;
            rvalid <= nrvalid;
            rlast  <= nrlast;
            done   <= ndone;
        end
    end

`ifdef MEMUNIT_ROM_PROTECT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= nerr;
        end
    end
`endif

    // Read port: rdata only changes on a read beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 8'h00;
        end else if (rd_en) begin
            rdata <= mem[cur.ptr];
        end
    end

    // Write port: contents survive reset, but a write coinciding
    // with reset is suppressed.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[cur.ptr] <= cur.wdata;
        end
    end

endmodule
